vedic_div16_seq: RTL and testbench



---
 rtl/vedic_div16_seq_if.sv | 25 ++
 rtl/vedic_div16_seq.sv | 123 ++++++++++++
 tb/tb_vedic_div16_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vedic_div16_seq_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// master drives operands and takes results; slave is the divider.
interface vedic_div16_seq_if #(
  parameter int W = 8
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/vedic_div16_seq.sv
// Sequential restoring divider, 2W/W -> 2W quotient + W remainder, 1 bit/clk.
// Optional DIV_ZERO_FAST_EN: zero divisor finishes one clock after accept.
module vedic_div16_seq #(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  vedic_div16_seq_if.slave io
);

  localparam int CW = $clog2(2 * W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] dvd_q, dvd_d;
  logic [W-1:0]   dsr_q, dsr_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           zero_q, zero_d;
  logic [2*W-1:0] quo_q, quo_d;
  logic [W-1:0]   rmd_q, rmd_d;
  logic           dbz_q, dbz_d;

  logic [W:0]     rem_sh;
  logic [W-1:0]   diff;
  logic           ge;
  logic [W-1:0]   rem_nx;
  logic [2*W-1:0] dvd_nx;
  logic           last;

  // The dividend register doubles as the quotient shift register.
  always_comb begin
    rem_sh = {rem_q, dvd_q[2*W-1]};
    ge     = rem_sh >= {1'b0, dsr_q};
    diff   = rem_sh[W-1:0] - dsr_q;
    rem_nx = ge ? diff : rem_sh[W-1:0];
    dvd_nx = {dvd_q[2*W-2:0], ge};
`ifdef DIV_ZERO_FAST_EN
    last   = (cnt_q == '0) || zero_q;
`else
    last   = (cnt_q == '0);
`endif
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (io.in_valid) begin
          state_d = S_CALC;
          dvd_d   = io.dividend;
          dsr_d   = io.divisor;
          lo_d    = io.dividend[W-1:0];
          zero_d  = (io.divisor == '0);
          rem_d   = '0;
          cnt_d   = CW'(2 * W - 1);
        end
      end
      state_q == S_CALC: begin
        dvd_d = dvd_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q - 1'b1;
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
          quo_d   = zero_q ? '1 : dvd_nx;
          rmd_d   = zero_q ? lo_q : rem_nx;
          dbz_d   = zero_q;
        end
      end
      state_q == S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign io.in_ready    = (state_q == S_IDLE);
  assign io.out_valid   = (state_q == S_DONE);
  assign io.quotient    = quo_q;
  assign io.remainder   = rmd_q;
  assign io.div_by_zero = dbz_q;

endmodule

// File: tb/tb_vedic_div16_seq.sv
// Self-checking bench for vedic_div16_seq: vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_vedic_div16_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vedic_div16_seq_if #(.W(W)) io ();

  vedic_div16_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dsr;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vecs[8];

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(logic [7:0] dsr);
    return (dsr == 8'h00 && FAST) ? 1 : 16;
  endfunction

  task automatic start_op(logic [15:0] dvd, logic [7:0] dsr);
    @(negedge clk);
    chk("in_ready_idle", 32'(io.in_ready), 32'd1);
    io.in_valid = 1'b1;
    io.dividend = dvd;
    io.divisor  = dsr;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_done(bit scr, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (scr) begin
        io.in_valid = 1'($urandom_range(0, 1));
        io.dividend = 16'($urandom);
        io.divisor  = 8'($urandom);
      end
    end while (!io.out_valid && lat < 40);
    chk("out_valid_timeout", 32'(io.out_valid), 32'd1);
  endtask

  task automatic take();
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("in_ready_after_take", 32'(io.in_ready), 32'd1);
    chk("out_valid_after_take", 32'(io.out_valid), 32'd0);
  endtask

  task automatic run_op(logic [15:0] dvd, logic [7:0] dsr, bit scr,
                        logic [15:0] q, logic [7:0] r, logic dbz);
    int lat;
    start_op(dvd, dsr);
    wait_done(scr, lat);
    chk("latency", 32'(lat), 32'(exp_lat(dsr)));
    chk("quotient", 32'(io.quotient), 32'(q));
    chk("remainder", 32'(io.remainder), 32'(r));
    chk("div_by_zero", 32'(io.div_by_zero), 32'(dbz));
    take();
  endtask

  initial begin
    int lat;
    logic [15:0] rd;
    logic [7:0]  rs;
    logic [15:0] mq;
    logic [7:0]  mr;

    vecs[0] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};
    vecs[1] = '{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0};
    vecs[2] = '{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0};
    vecs[3] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1};
    vecs[4] = '{16'h0000, 8'h03, 16'h0000, 8'h00, 1'b0};
    vecs[5] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0};
    vecs[6] = '{16'hFFFE, 8'hFF, 16'h0100, 8'hFE, 1'b0};
    vecs[7] = '{16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0};

    io.in_valid  = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;
    io.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_quotient", 32'(io.quotient), 32'd0);
    chk("rst_remainder", 32'(io.remainder), 32'd0);
    chk("rst_dbz", 32'(io.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].dvd, vecs[i].dsr, 1'b0, vecs[i].q, vecs[i].r,
             vecs[i].dbz);

    // Result held 5 cycles under back-pressure with noisy inputs.
    start_op(16'h03E8, 8'h07);
    wait_done(1'b0, lat);
    chk("hold_latency", 32'(lat), 32'd16);
    for (int i = 0; i < 5; i++) begin
      io.in_valid = 1'b1;
      io.dividend = 16'($urandom);
      io.divisor  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", 32'(io.out_valid), 32'd1);
      chk("hold_in_ready", 32'(io.in_ready), 32'd0);
      chk("hold_quotient", 32'(io.quotient), 32'h008E);
      chk("hold_remainder", 32'(io.remainder), 32'h06);
    end
    take();
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_stays", 32'(io.in_ready), 32'd1);
    chk("hold_keep_q", 32'(io.quotient), 32'h008E);

    // Async reset mid-calculation drops the operation.
    start_op(16'h1234, 8'h05);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_quotient", 32'(io.quotient), 32'd0);
    chk("midrst_remainder", 32'(io.remainder), 32'd0);
    chk("midrst_dbz", 32'(io.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0064, 8'h0A, 1'b0, 16'h000A, 8'h00, 1'b0);

    // Random operations, operands scrambled while busy.
    for (int i = 0; i < 30; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300))
                                       : 16'($urandom);
      rs = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if (rs == 8'h00) begin
        mq = 16'hFFFF;
        mr = rd[7:0];
      end else begin
        mq = rd / {8'h00, rs};
        mr = 8'(rd % {8'h00, rs});
      end
      run_op(rd, rs, 1'b1, mq, mr, rs == 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
